iq_hard_demapper: RTL

//  Pipelined multi-mode hard-decision demapper. Takes signed I/Q symbols from the demodulator chain and emits Gray-coded bits.

---
 rtl/iq_hard_demapper.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/iq_hard_demapper.sv
// Two-stage elastic hard-decision demapper for BPSK/QPSK/16QAM I/Q symbols.
// Stage 1 captures signs and saturated magnitudes; stage 2 holds the Gray-coded decision.
module iq_hard_demapper #(
  parameter int DW    = 16,
  parameter int CNT_W = 32
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [DW-1:0]    i_i,
  input  logic [DW-1:0]    i_q,
  input  logic [1:0]       i_mode,
  input  logic [DW-2:0]    i_thr,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [3:0]       o_bits,
  output logic [2:0]       o_nbits,
  output logic             o_err,
  output logic [CNT_W-1:0] o_sym_cnt
);

  localparam logic [1:0] MODE_BPSK  = 2'd0;
  localparam logic [1:0] MODE_QPSK  = 2'd1;
  localparam logic [1:0] MODE_QAM16 = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  localparam logic [DW-2:0]    MAG_ONE = {{(DW-2){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Channel index 1 is I, index 0 is Q throughout.
  logic [1:0][DW-1:0] sample;
  logic [1:0]         sign_next;
  logic [1:0][DW-2:0] mag_next;
  logic [1:0]         inner;

  logic               run_reg;
  logic               s1_valid_reg;
  logic [1:0]         s1_sign_reg;
  logic [1:0][DW-2:0] s1_mag_reg;
  logic [1:0]         s1_mode_reg;
  logic [DW-2:0]      s1_thr_reg;

  logic               s2_valid_reg;
  logic [3:0]         s2_bits_reg;
  logic [2:0]         s2_nbits_reg;
  logic               err_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic               in_fire;
  logic               out_fire;
  logic               s2_load;
  logic               s1_drop;
  logic               s2_take;
  logic [3:0]         bits_next;
  logic [2:0]         nbits_next;

  assign sample[1] = i_i;
  assign sample[0] = i_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      assign sign_next[gi] = sample[gi][DW-1];
      // The most negative value has no positive twin, so it clamps to full scale.
      assign mag_next[gi] = !sample[gi][DW-1]              ? sample[gi][DW-2:0] :
                            (sample[gi][DW-2:0] == '0)     ? {(DW-1){1'b1}} :
                            (~sample[gi][DW-2:0] + MAG_ONE);
      assign inner[gi] = (s1_mag_reg[gi] < s1_thr_reg);
    end
  endgenerate

  assign out_fire = s2_valid_reg && i_ready;
  assign s2_load  = !s2_valid_reg || out_fire;
  assign o_ready  = run_reg && (!s1_valid_reg || s2_load);
  assign in_fire  = i_valid && o_ready;
  assign s1_drop  = s1_valid_reg && (s1_mode_reg == MODE_RSVD);
  assign s2_take  = s2_load && s1_valid_reg && !s1_drop;

  always_comb begin
    bits_next  = 4'b0000;
    nbits_next = 3'd0;
    case (s1_mode_reg)
      MODE_BPSK: begin
        bits_next  = {3'b000, s1_sign_reg[1]};
        nbits_next = 3'd1;
      end
      MODE_QPSK: begin
        bits_next  = {2'b00, s1_sign_reg[1], s1_sign_reg[0]};
        nbits_next = 3'd2;
      end
      MODE_QAM16: begin
        bits_next  = {s1_sign_reg[1], inner[1], s1_sign_reg[0], inner[0]};
        nbits_next = 3'd4;
      end
      default: begin
        bits_next  = 4'b0000;
        nbits_next = 3'd0;
      end
    endcase
  end

  // Stage 1: input capture. It empties whenever stage 2 consumes or drops its symbol.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      run_reg      <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_sign_reg  <= '0;
      s1_mag_reg   <= '0;
      s1_mode_reg  <= '0;
      s1_thr_reg   <= '0;
    end else begin
      run_reg <= 1'b1;
      if (in_fire) begin
        s1_valid_reg <= 1'b1;
        s1_sign_reg  <= sign_next;
        s1_mag_reg   <= mag_next;
        s1_mode_reg  <= i_mode;
        s1_thr_reg   <= i_thr;
      end else if (s2_load) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  // Stage 2: decision register. A reserved-mode symbol leaves it empty and raises o_err.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      s2_valid_reg <= 1'b0;
      s2_bits_reg  <= '0;
      s2_nbits_reg <= '0;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      err_reg <= s2_load && s1_drop;
      if (s2_load) begin
        s2_valid_reg <= s2_take;
        if (s2_take) begin
          s2_bits_reg  <= bits_next;
          s2_nbits_reg <= nbits_next;
        end
      end
      if (out_fire) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

  assign o_valid   = s2_valid_reg;
  assign o_bits    = s2_bits_reg;
  assign o_nbits   = s2_nbits_reg;
  assign o_err     = err_reg;
  assign o_sym_cnt = cnt_reg;

endmodule
